uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter (`UART_TOP` TX path: `data_in`/`transmit`/`TX_active`) between `NUM_REQ` byte-producing requesters. It latches the winning requester's byte, drives the transmitter's start strobe, tracks the frame through `TX_active`, and returns a one-cycle completion pulse to the owner before rotating priority. It sits between the requester logic and `UART_TOP`.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `DATA_WIDTH`, 8, byte width per requester
- `TIMEOUT_CYCLES`, 4096, watchdog limit per phase (used only with `UART_ARB_TIMEOUT_EN`)

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous reset, active-high
- `req` in NUM_REQ: per-requester request level
- `req_data` in NUM_REQ*DATA_WIDTH: requester i's byte at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `done` out NUM_REQ: one-cycle pulse to the owner when its frame has finished or been aborted
- `abort` out 1: one-cycle pulse coincident with `done` when the watchdog ended the transfer
- `tx_data` out DATA_WIDTH: to UART `data_in`
- `tx_start` out 1: to UART `transmit`
- `tx_active` in 1: from UART `TX_active`
- `busy` out 1: high in every state except IDLE
- `grant_id` out max(1,$clog2(NUM_REQ)): index of current/last owner

## Operation
- Reset values: `tx_start`=0, `tx_data`=0, `done`=0, `abort`=0, `busy`=0, `grant_id`=0, state=IDLE, last-grant pointer=NUM_REQ-1 (requester 0 has first priority).
- Requester contract: raise `req[i]` with `req_data` slice stable; hold both until `done[i]`. A `req[i]` still high in the cycle after `done[i]` is a new request.
- States:
  - IDLE: if `req`≠0, select first set bit searching from (last+1) mod NUM_REQ upward with wrap; register `tx_data`←slice, `grant_id`←winner; go START. Else stay.
  - START: `tx_start`=1; when `tx_active`=1 sampled, go WAIT_DONE.
  - WAIT_DONE: `tx_start`=0; when `tx_active`=0 sampled, pulse `done[grant_id]`, last←`grant_id`, go IDLE.
- `tx_data` holds the latched byte from IDLE exit until next grant; never changes while `busy`.
- `req` changes or deassertion while `busy` are ignored; owner is never preempted.
- At most one bit of `done` is set in any cycle.
- `reset` at any state returns all outputs to reset values next edge; no `done` is issued for the interrupted transfer.

## Timing
- Cycle 0: IDLE samples `req`≠0. Cycle 1: state START, `tx_start`=1, `busy`=1, `tx_data` valid.
- `tx_start` stays high until the edge after `tx_active` is first seen high (minimum 1 cycle).
- `done` asserts in the cycle state returns to IDLE, i.e. 1 cycle after `tx_active` is sampled low in WAIT_DONE; `busy`=0 in that same cycle.
- Earliest next grant: IDLE decision in the `done` cycle, `tx_start` again the following cycle (back-to-back gap of 1 idle cycle on `tx_start`).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined: a counter clears on each state entry and increments in START and WAIT_DONE; reaching `TIMEOUT_CYCLES` forces `tx_start`=0, pulses `done[grant_id]` and `abort`, updates last pointer, and returns to IDLE.
- Not defined: no counter; `abort` tied 0; START/WAIT_DONE wait indefinitely.

## Test plan
- Single request: `req`=4'b0100, byte 8'hAC, UART model raises `tx_active` 2 cycles after `tx_start`, holds 20 cycles -> `tx_start` high 3 cycles, `tx_data`=8'hAC, `done`=4'b0100 once, `grant_id`=2.
- All four requesting continuously after reset -> grant order 0,1,2,3,0; each `done` bit exactly once per round; `tx_start` rising edges 1 idle cycle after each `done`.
- Requester 1 changes `req_data` and drops `req` mid-frame -> `tx_data` unchanged, `done[1]` still pulses at frame end.
- `reset` pulsed during WAIT_DONE -> next cycle `busy`=0, `tx_start`=0, `tx_data`=0, no `done`; next grant goes to requester 0.
- With `UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `tx_active` stuck 0 -> `done[grant_id]` and `abort` pulse 16 cycles after START entry, `tx_start` drops; without macro, arbiter remains in START with `tx_start`=1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter between
// NUM_REQ byte producers. Latches the winner's byte, strobes the transmitter,
// follows the frame through tx_active and returns a one-cycle done pulse.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort a transfer that
// stays in START or WAIT_DONE for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    localparam int unsigned ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            done,
    output logic                          abort,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_start,
    input  logic                          tx_active,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    // Reject configurations outside the supported range at elaboration
    if (NUM_REQ < 2 || NUM_REQ > 16 || DATA_WIDTH == 0 || TIMEOUT_CYCLES == 0) begin : g_cfg_err
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    logic [ID_W-1:0]         last_q, last_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    tx_start_q, tx_start_d;
    logic                    busy_q, busy_d;

    logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];
    logic                    win_vld;
    logic [ID_W-1:0]         win_id;
    logic [ID_W-1:0]         cand;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                    abort_q, abort_d;
    logic                    tmo_hit;
`endif

    // Split the flat request bus into per-requester bytes
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: first set request after the last owner, with wrap
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last_q) + k) % NUM_REQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    assign tmo_hit = (state_q != ST_IDLE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        last_d    = last_q;
        done_d    = '0;
`ifdef UART_ARB_TIMEOUT_EN
        abort_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d   = ST_START;
                    tx_data_d = req_bytes[win_id];
                    grant_d   = win_id;
                end
            end
            ST_START: begin
                if (tx_active) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_active) begin
                    state_d = ST_IDLE;
                    done_d  = NUM_REQ'(1) << grant_q;
                    last_d  = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog overrides any normal progress in the same cycle
        if (tmo_hit) begin
            state_d = ST_IDLE;
            done_d  = NUM_REQ'(1) << grant_q;
            abort_d = 1'b1;
            last_d  = grant_q;
        end
        tmo_cnt_d = (state_d != state_q || state_q == ST_IDLE) ? '0
                                                                : tmo_cnt_q + CNT_W'(1);
`endif

        tx_start_d = (state_d == ST_START);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            grant_q    <= '0;
            last_q     <= ID_W'(NUM_REQ - 1);
            done_q     <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            done_q     <= done_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog counter and abort flag
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            abort_q   <= abort_d;
        end
    end

    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: UART TX model, scoreboard of
// expected completions, and directed scenarios (single, round-robin,
// mid-frame data change, reset mid-frame, stuck transmitter).
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned TMO  = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0] done;
    logic            abort;
    logic [DW-1:0]   tx_data;
    logic            tx_start;
    logic            tx_active = 1'b0;
    logic            busy;
    logic [1:0]      grant_id;

    uart_tx_arbiter #(
        .NUM_REQ        (NREQ),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .done      (done),
        .abort     (abort),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_active (tx_active),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         len;
        logic       abrt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // UART TX model: raises tx_active rise_lat cycles into tx_start, holds it hold cycles
    bit uart_en  = 1'b1;
    int rise_lat = 3;
    int hold     = 20;
    int scnt     = 0;
    int hcnt     = 0;

    always @(negedge clk) begin
        if (reset || !uart_en) begin
            tx_active = 1'b0;
            scnt = 0;
            hcnt = 0;
        end else if (tx_active) begin
            hcnt++;
            if (hcnt >= hold) begin
                tx_active = 1'b0;
                hcnt = 0;
            end
        end else if (tx_start) begin
            scnt++;
            if (scnt >= rise_lat) begin
                tx_active = 1'b1;
                scnt = 0;
            end
        end else begin
            scnt = 0;
        end
    end

    // Monitor: pops the scoreboard on each done pulse and checks the completed frame
    int        st_len     = 0;
    logic      prev_start = 1'b0;
    logic [3:0] prev_done = '0;
    bit        gap_en     = 1'b0;
    exp_t      e;

    always @(negedge clk) begin
        if (tx_start && !prev_start) begin
            st_len = 1;
            if (gap_en) check_eq("b2b_gap", 32'(prev_done != 4'd0), 32'd1);
        end else if (tx_start) begin
            st_len++;
        end
        if (done != 4'd0) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("done_vec",  32'(done),     32'd1 << e.id);
                check_eq("grant_id",  32'(grant_id), 32'(e.id));
                check_eq("tx_data",   32'(tx_data),  32'(e.data));
                check_eq("start_len", 32'(st_len),   32'(e.len));
                check_eq("abort",     32'(abort),    32'(e.abrt));
                check_eq("busy_at_done", 32'(busy),  32'd0);
            end
        end else if (abort) begin
            check_eq("abort_without_done", 32'(abort), 32'd0);
        end
        prev_start = tx_start;
        prev_done  = done;
    end

    // Wait for a done pulse; drop the finished requester's req bits listed in drop_mask
    task automatic wait_done(input int max_cyc, input logic [3:0] drop_mask,
                             output logic [3:0] seen, output int cyc);
        seen = '0;
        cyc  = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (done != 4'd0) begin
                seen = done;
                cyc  = c + 1;
                req  = req & ~(done & drop_mask);
                return;
            end
        end
        check_eq("done_timeout", 32'(done != 4'd0), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [3:0] seen;
    int         cyc;
    int         rr_order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] rr_data  [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_tx_start", 32'(tx_start), 32'd0);
        check_eq("rst_tx_data",  32'(tx_data),  32'd0);
        check_eq("rst_done",     32'(done),     32'd0);
        check_eq("rst_abort",    32'(abort),    32'd0);
        check_eq("rst_busy",     32'(busy),     32'd0);
        check_eq("rst_grant",    32'(grant_id), 32'd0);
        reset = 1'b0;

        // Single request from requester 2
        req_data = {8'h11, 8'hAC, 8'h22, 8'h33};
        sb_q.push_back('{id: 2, data: 8'hAC, len: 3, abrt: 1'b0});
        req = 4'b0100;
        wait_done(200, 4'hF, seen, cyc);
        check_eq("t1_seen", 32'(seen), 32'h4);
        check_eq("t1_latency", 32'(cyc), 32'd24);
        repeat (10) @(negedge clk);

        // All four requesting continuously after reset: order 0,1,2,3,0
        do_reset();
        req_data = {rr_data[3], rr_data[2], rr_data[1], rr_data[0]};
        for (int i = 0; i < 5; i++)
            sb_q.push_back('{id: rr_order[i], data: rr_data[rr_order[i]], len: 3, abrt: 1'b0});
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_done(200, 4'h0, seen, cyc);
            check_eq("rr_order", 32'(seen), 32'd1 << rr_order[i]);
            if (i == 0) gap_en = 1'b1;
            if (i == 4) req = '0;
        end
        gap_en = 1'b0;
        repeat (5) @(negedge clk);

        // Requester 1 changes data and drops req mid-frame
        req_data = {8'h00, 8'h00, 8'h5A, 8'h00};
        sb_q.push_back('{id: 1, data: 8'h5A, len: 3, abrt: 1'b0});
        req = 4'b0010;
        repeat (6) @(negedge clk);
        check_eq("t3_busy",     32'(busy),     32'd1);
        check_eq("t3_tx_start", 32'(tx_start), 32'd0);
        req_data = {8'h00, 8'h00, 8'hFF, 8'h00};
        req      = 4'b0000;
        @(negedge clk);
        check_eq("t3_data_held", 32'(tx_data), 32'h5A);
        wait_done(200, 4'hF, seen, cyc);
        check_eq("t3_seen", 32'(seen), 32'h2);
        repeat (5) @(negedge clk);

        // Reset during WAIT_DONE; pointer returns so requester 0 wins next
        req_data = {8'h77, 8'h00, 8'h00, 8'h66};
        req = 4'b1001;
        repeat (6) @(negedge clk);
        check_eq("t4_grant_pre", 32'(grant_id), 32'd3);
        check_eq("t4_busy_pre",  32'(busy),     32'd1);
        check_eq("t4_wait_done", 32'(tx_start), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t4_busy",     32'(busy),     32'd0);
        check_eq("t4_tx_start", 32'(tx_start), 32'd0);
        check_eq("t4_tx_data",  32'(tx_data),  32'd0);
        check_eq("t4_done",     32'(done),     32'd0);
        check_eq("t4_grant",    32'(grant_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sb_q.push_back('{id: 0, data: 8'h66, len: 3, abrt: 1'b0});
        wait_done(200, 4'hF, seen, cyc);
        req = '0;
        check_eq("t4_seen", 32'(seen), 32'h1);
        repeat (5) @(negedge clk);

        // Transmitter stuck: tx_active never rises
        uart_en  = 1'b0;
        req_data = {8'h00, 8'h00, 8'h00, 8'h3C};
`ifdef UART_ARB_TIMEOUT_EN
        sb_q.push_back('{id: 0, data: 8'h3C, len: int'(TMO), abrt: 1'b1});
        req = 4'b0001;
        wait_done(100, 4'hF, seen, cyc);
        check_eq("t5_seen",    32'(seen), 32'h1);
        check_eq("t5_latency", 32'(cyc),  32'(TMO + 1));
        @(negedge clk);
        check_eq("t5_tx_start_after", 32'(tx_start), 32'd0);
        check_eq("t5_busy_after",     32'(busy),     32'd0);
`else
        req = 4'b0001;
        repeat (40) @(negedge clk);
        check_eq("t5_busy",     32'(busy),     32'd1);
        check_eq("t5_tx_start", 32'(tx_start), 32'd1);
        check_eq("t5_grant",    32'(grant_id), 32'd0);
        check_eq("t5_tx_data",  32'(tx_data),  32'h3C);
        req = '0;
        do_reset();
`endif
        repeat (5) @(negedge clk);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
